regfile_cmd_sequencer: RTL and testbench



---
 rtl/regfile_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_regfile_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_sequencer.sv
// rtl/regfile_cmd_sequencer.sv - in-order command FIFO and bus sequencer for the 8x4 register file
// Commands are queued, issued one at a time on a registered RW/Address/Data_in bus, reads are returned on Rsp_*.
module regfile_cmd_sequencer #(
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          Cmd_valid,
   output logic                          Cmd_ready,
   input  logic                          Cmd_write,
   input  logic [ADDR_W-1:0]             Cmd_addr,
   input  logic [DATA_W-1:0]             Cmd_data,
   output logic                          RW,
   output logic [ADDR_W-1:0]             Address,
   output logic [DATA_W-1:0]             Data_in,
   input  logic [DATA_W-1:0]             Data_out,
   output logic                          Rsp_valid,
   input  logic                          Rsp_ready,
   output logic [ADDR_W-1:0]             Rsp_addr,
   output logic [DATA_W-1:0]             Rsp_data,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   Cmd_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]       LAT_C   = 2'(READ_LATENCY);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_WAIT = 2'd2,
      RSP     = 2'd3
   } state_t;

   // FIFO storage needs no reset: the pointers and count define validity.
   logic              fifo_wr_mem   [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   state_t            state_q, state_d;
   logic [1:0]        lat_q, lat_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              fifo_empty;
   logic              cmd_ready;
   logic              push;
   logic              pop;
   logic              issue;
   logic              head_write;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q < DEPTH_C);
   assign push       = Cmd_valid & cmd_ready;
   assign head_write = fifo_wr_mem[rd_ptr_q];
   assign head_addr  = fifo_addr_mem[rd_ptr_q];
   assign head_data  = fifo_data_mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      din_d       = din_q;
      rsp_valid_d = rsp_valid_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      issue       = 1'b0;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            rw_d = 1'b0;
            if (!fifo_empty) issue = 1'b1;
         end
         WR: begin
            if (!fifo_empty) begin
               issue = 1'b1;
            end else begin
               rw_d    = 1'b0;
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (lat_q == 2'd0) begin
               rsp_valid_d = 1'b1;
               rsp_addr_d  = addr_q;
               rsp_data_d  = Data_out;
               state_d     = RSP;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         RSP: begin
            if (Rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!fifo_empty) issue = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Shared issue path so WR and RSP can chain into the next command without an IDLE bubble.
      if (issue) begin
         pop    = 1'b1;
         addr_d = head_addr;
         if (head_write) begin
            rw_d    = 1'b1;
            din_d   = head_data;
            state_d = WR;
         end else begin
            rw_d    = 1'b0;
            lat_d   = LAT_C;
            state_d = RD_WAIT;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_wr_mem[wr_ptr_q]   <= Cmd_write;
         fifo_addr_mem[wr_ptr_q] <= Cmd_addr;
         fifo_data_mem[wr_ptr_q] <= Cmd_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         lat_q       <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         lat_q       <= lat_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign Cmd_ready = cmd_ready;
   assign RW        = rw_q;
   assign Address   = addr_q;
   assign Data_in   = din_q;
   assign Rsp_valid = rsp_valid_q;
   assign Rsp_addr  = rsp_addr_q;
   assign Rsp_data  = rsp_data_q;
   assign Busy      = (state_q != IDLE) | !fifo_empty;
   assign Cmd_count = count_q;

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// tb/tb_regfile_cmd_sequencer.sv - self-checking bench for regfile_cmd_sequencer
// Scoreboard tracks command-order semantics of an 8x4 register file; hand sequences cover timing corners.
module tb_regfile_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
   logic [2:0] cmd_addr = '0;
   logic [3:0] cmd_data = '0;
   logic       cmd_ready, rw, rsp_valid, busy;
   logic [2:0] address, rsp_addr;
   logic [3:0] data_in, data_out, rsp_data;
   logic [2:0] cmd_count;

   logic       cmd_valid0 = 1'b0, cmd_write0 = 1'b0, rsp_ready0 = 1'b1;
   logic [2:0] cmd_addr0 = '0;
   logic [3:0] cmd_data0 = '0;
   logic       cmd_ready0, rw0, rsp_valid0, busy0;
   logic [2:0] address0, rsp_addr0;
   logic [3:0] data_in0, data_out0, rsp_data0;
   logic [2:0] cmd_count0;

   regfile_cmd_sequencer #(.ADDR_W(3), .DATA_W(4), .FIFO_DEPTH(4), .READ_LATENCY(1)) u_dut (
      .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid), .Cmd_ready(cmd_ready), .Cmd_write(cmd_write),
      .Cmd_addr(cmd_addr), .Cmd_data(cmd_data), .RW(rw), .Address(address), .Data_in(data_in),
      .Data_out(data_out), .Rsp_valid(rsp_valid), .Rsp_ready(rsp_ready), .Rsp_addr(rsp_addr),
      .Rsp_data(rsp_data), .Busy(busy), .Cmd_count(cmd_count));

   regfile_cmd_sequencer #(.ADDR_W(3), .DATA_W(4), .FIFO_DEPTH(4), .READ_LATENCY(0)) u_dut_l0 (
      .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid0), .Cmd_ready(cmd_ready0), .Cmd_write(cmd_write0),
      .Cmd_addr(cmd_addr0), .Cmd_data(cmd_data0), .RW(rw0), .Address(address0), .Data_in(data_in0),
      .Data_out(data_out0), .Rsp_valid(rsp_valid0), .Rsp_ready(rsp_ready0), .Rsp_addr(rsp_addr0),
      .Rsp_data(rsp_data0), .Busy(busy0), .Cmd_count(cmd_count0));

   // Register file models: registered read for latency 1, combinational read for latency 0.
   logic [3:0] rf_mem  [8];
   logic [3:0] rf0_mem [8];
   initial for (int i = 0; i < 8; i++) begin rf_mem[i] = '0; rf0_mem[i] = '0; end
   always @(posedge clk) begin
      if (rw) rf_mem[address] <= data_in;
      data_out <= rf_mem[address];
   end
   always @(posedge clk) if (rw0) rf0_mem[address0] <= data_in0;
   assign data_out0 = rf0_mem[address0];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [3:0] data;
   } op_t;
   op_t        exp_q[$];
   logic [3:0] model_mem [8];
   initial for (int i = 0; i < 8; i++) model_mem[i] = '0;

   // Every bus write and every consumed response must match the next accepted command in order.
   always @(negedge clk) begin
      op_t op;
      if (rst) begin
         exp_q.delete();
      end else begin
         n_checks++;
         if (!busy && exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_with_pending actual=%0d required=0", exp_q.size());
         end
         if (rw) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_bus_write actual=1 required=0");
            end else begin
               op = exp_q.pop_front();
               chk("bus_write_kind", 32'(op.wr), 32'd1);
               chk("bus_write_addr", 32'(address), 32'(op.addr));
               chk("bus_write_data", 32'(data_in), 32'(op.data));
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_response actual=1 required=0");
            end else begin
               op = exp_q.pop_front();
               chk("rsp_kind", 32'(op.wr), 32'd0);
               chk("rsp_addr", 32'(rsp_addr), 32'(op.addr));
               chk("rsp_data", 32'(rsp_data), 32'(op.data));
            end
         end
         chk("cmd_ready_vs_count", 32'(cmd_ready), 32'(cmd_count < 3'd4));
         if (cmd_valid && cmd_ready) begin
            op.wr   = cmd_write;
            op.addr = cmd_addr;
            if (cmd_write) model_mem[cmd_addr] = cmd_data;
            op.data = model_mem[cmd_addr];
            exp_q.push_back(op);
         end
      end
   end

   task automatic push_any(input bit l0, input logic w, input logic [2:0] a, input logic [3:0] d);
      if (l0) begin cmd_valid0 = 1'b1; cmd_write0 = w; cmd_addr0 = a; cmd_data0 = d; end
      else    begin cmd_valid  = 1'b1; cmd_write  = w; cmd_addr  = a; cmd_data  = d; end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (l0 ? cmd_ready0 : cmd_ready) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0; cmd_valid0 = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0; cmd_valid0 = 1'b0;
      chk("push_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy && !busy0) begin
            @(posedge clk); #1;
            return;
         end
      end
      chk(nm, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [3:0] data;
   } vec_t;
   vec_t       vecs [6];
   logic [2:0] rsp_exp_addr [3];
   logic [3:0] rsp_exp_data [3];

   initial begin
      logic [3:0] exp0;
      int         cnt;
      bit         seen;

      vecs[0] = '{1'b1, 3'd4, 4'd4};
      vecs[1] = '{1'b1, 3'd5, 4'd5};
      vecs[2] = '{1'b0, 3'd5, 4'd0};
      vecs[3] = '{1'b0, 3'd4, 4'd0};
      vecs[4] = '{1'b1, 3'd6, 4'd6};
      vecs[5] = '{1'b0, 3'd6, 4'd0};
      rsp_exp_addr[0] = 3'd5; rsp_exp_data[0] = 4'd5;
      rsp_exp_addr[1] = 3'd4; rsp_exp_data[1] = 4'd4;
      rsp_exp_addr[2] = 3'd6; rsp_exp_data[2] = 4'd6;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rw", 32'(rw), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_count", 32'(cmd_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Back-to-back writes
      push_any(0, 1'b1, 3'd1, 4'd1);
      push_any(0, 1'b1, 3'd2, 4'd2);
      @(negedge clk);
      chk("wr1_rw", 32'(rw), 32'd1);
      chk("wr1_addr", 32'(address), 32'd1);
      chk("wr1_data", 32'(data_in), 32'd1);
      @(negedge clk);
      chk("wr2_rw", 32'(rw), 32'd1);
      chk("wr2_addr", 32'(address), 32'd2);
      chk("wr2_data", 32'(data_in), 32'd2);
      chk("wr2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("wr_done_rw", 32'(rw), 32'd0);
      chk("wr_done_busy", 32'(busy), 32'd0);
      chk("wr_park_addr", 32'(address), 32'd2);
      @(posedge clk); #1;

      // Read after write with exact turnaround
      rsp_ready = 1'b1;
      push_any(0, 1'b1, 3'd3, 4'd3);
      push_any(0, 1'b0, 3'd3, 4'd0);
      @(negedge clk);
      chk("raw_wr_rw", 32'(rw), 32'd1);
      @(negedge clk);
      chk("raw_issue_rw", 32'(rw), 32'd0);
      chk("raw_issue_addr", 32'(address), 32'd3);
      @(negedge clk);
      chk("raw_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("raw_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("raw_rsp_addr", 32'(rsp_addr), 32'd3);
      chk("raw_rsp_data", 32'(rsp_data), 32'd3);
      cnt = 0;
      repeat (8) begin @(negedge clk); if (rsp_valid) cnt++; end
      chk("raw_extra_rsp", 32'(cnt), 32'd0);
      @(posedge clk); #1;

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = 3'($urandom_range(0, 7));
         cmd_data  = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle("random_drain_timeout");
      chk("random_pending", 32'(exp_q.size()), 32'd0);

      // Full FIFO with a stalled response
      exp0 = model_mem[0];
      rsp_ready = 1'b0;
      push_any(0, 1'b0, 3'd0, 4'd0);
      push_any(0, 1'b1, 3'd1, 4'd6);
      push_any(0, 1'b0, 3'd1, 4'd0);
      push_any(0, 1'b1, 3'd2, 4'd7);
      push_any(0, 1'b0, 3'd2, 4'd0);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd3; cmd_data = 4'd15;
      repeat (4) begin
         @(negedge clk);
         chk("full_count", 32'(cmd_count), 32'd4);
         chk("full_ready", 32'(cmd_ready), 32'd0);
         chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("full_rsp_addr", 32'(rsp_addr), 32'd0);
         chk("full_rsp_data", 32'(rsp_data), 32'(exp0));
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle("full_drain_timeout");
      chk("full_pending", 32'(exp_q.size()), 32'd0);
      chk("full_extra_ignored", 32'(rf_mem[3]), 32'(model_mem[3]));

      // Mixed in-order sequence from the vector table
      fork
         begin
            for (int i = 0; i < 6; i++) push_any(0, vecs[i].wr, vecs[i].addr, vecs[i].data);
         end
         begin
            for (int j = 0; j < 3; j++) begin
               seen = 1'b0;
               for (int c = 0; c < 100 && !seen; c++) begin
                  @(negedge clk);
                  if (rsp_valid && rsp_ready) seen = 1'b1;
               end
               chk("mix_rsp_seen", 32'(seen), 32'd1);
               chk("mix_rsp_addr", 32'(rsp_addr), 32'(rsp_exp_addr[j]));
               chk("mix_rsp_data", 32'(rsp_data), 32'(rsp_exp_data[j]));
            end
         end
      join
      wait_idle("mix_drain_timeout");
      chk("mix_count", 32'(cmd_count), 32'd0);

      // Reset during RD_WAIT with two commands queued
      push_any(0, 1'b0, 3'd1, 4'd0);
      push_any(0, 1'b0, 3'd2, 4'd0);
      push_any(0, 1'b0, 3'd3, 4'd0);
      @(negedge clk);
      chk("pre_rst_count", 32'(cmd_count), 32'd2);
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_count", 32'(cmd_count), 32'd0);
      chk("midrst_rw", 32'(rw), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      cnt = 0;
      repeat (10) begin @(negedge clk); if (rsp_valid) cnt++; end
      chk("midrst_no_rsp", 32'(cnt), 32'd0);
      @(posedge clk); #1;

      // READ_LATENCY=0 instance with combinational read
      rsp_ready0 = 1'b1;
      push_any(1, 1'b1, 3'd7, 4'd7);
      push_any(1, 1'b0, 3'd7, 4'd0);
      @(negedge clk);
      chk("l0_wr_rw", 32'(rw0), 32'd1);
      @(negedge clk);
      chk("l0_issue_rsp_valid", 32'(rsp_valid0), 32'd0);
      chk("l0_issue_addr", 32'(address0), 32'd7);
      @(negedge clk);
      chk("l0_rsp_valid", 32'(rsp_valid0), 32'd1);
      chk("l0_rsp_addr", 32'(rsp_addr0), 32'd7);
      chk("l0_rsp_data", 32'(rsp_data0), 32'd7);
      @(posedge clk); #1;
      wait_idle("l0_drain_timeout");
      chk("l0_count", 32'(cmd_count0), 32'd0);

      chk("final_pending", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
